vga_draw_arbiter: RTL and testbench

- Shares the single vga_adapter pixel-write port (x, y, colour, plot) between several drawing requesters: paddle, ball, block and screen-clear logic.
- Each requester submits a filled-rectangle job. The block arbitrates round-robin, latches the winning job and rasterises it at one pixel per clock.
- It sits between the game FSM and vga_adapter, and replaces the per-state hand-muxing of x/y/colour and the draw_counter loops.

---
 rtl/vga_draw_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that shares the vga_adapter pixel port between rectangle-drawing
// requesters, latching the winning job and rasterising it one pixel per clock.
module vga_draw_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [4*NUM_REQ-1:0] req_wm1,
    input  logic [4*NUM_REQ-1:0] req_hm1,
    input  logic [3*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [8:0] SCREEN_H9 = 9'(SCREEN_H);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t state, next_state;

    logic [PW-1:0]      ptr, ptr_nxt;
    logic [PW-1:0]      cur_idx, cur_idx_nxt;
    logic [PW-1:0]      win_idx;
    logic               win_valid;
    int                 scan_idx;

    logic [7:0]         lat_x, lat_x_nxt;
    logic [6:0]         lat_y, lat_y_nxt;
    logic [3:0]         lat_wm1, lat_wm1_nxt;
    logic [3:0]         lat_hm1, lat_hm1_nxt;
    logic [3:0]         ox, ox_nxt, oy, oy_nxt;
    logic [3:0]         adv_ox, adv_oy;
    logic               last_pix;

    logic [7:0]         sel_x;
    logic [6:0]         sel_y;
    logic [3:0]         sel_wm1, sel_hm1;
    logic [2:0]         sel_colour;

    logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
    logic               busy_nxt, plot_nxt;
    logic [7:0]         vga_x_nxt;
    logic [6:0]         vga_y_nxt;
    logic [2:0]         colour_nxt;
    logic [15:0]        first_pix, adv_pix;

    // Returns {plot, x, y}; sums are 9 bits wide so off-screen pixels are detected, not wrapped.
    function automatic logic [15:0] pixel(input logic [7:0] bx, input logic [6:0] by,
                                          input logic [3:0] dx, input logic [3:0] dy);
        logic [8:0] sx;
        logic [8:0] sy;
        sx = {1'b0, bx} + {5'b0, dx};
        sy = {2'b0, by} + {5'b0, dy};
        return {(sx < SCREEN_W9) && (sy < SCREEN_H9), sx[7:0], sy[6:0]};
    endfunction

    // First asserted request searching upward from the rotating pointer.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!win_valid && req[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = PW'(scan_idx);
            end
        end
    end

    assign sel_x      = req_x[8*win_idx +: 8];
    assign sel_y      = req_y[7*win_idx +: 7];
    assign sel_wm1    = req_wm1[4*win_idx +: 4];
    assign sel_hm1    = req_hm1[4*win_idx +: 4];
    assign sel_colour = req_colour[3*win_idx +: 3];

    assign last_pix = (ox == lat_wm1) && (oy == lat_hm1);

    always_comb begin
        adv_ox = ox + 4'd1;
        adv_oy = oy;
        if (ox == lat_wm1) begin
            adv_ox = 4'd0;
            adv_oy = oy + 4'd1;
        end
    end

    assign first_pix = pixel(sel_x, sel_y, 4'd0, 4'd0);
    assign adv_pix   = pixel(lat_x, lat_y, adv_ox, adv_oy);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_valid) next_state = DRAW;
            DRAW:    if (last_pix)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt     = ptr;
        cur_idx_nxt = cur_idx;
        lat_x_nxt   = lat_x;
        lat_y_nxt   = lat_y;
        lat_wm1_nxt = lat_wm1;
        lat_hm1_nxt = lat_hm1;
        ox_nxt      = ox;
        oy_nxt      = oy;
        gnt_nxt     = gnt;
        done_nxt    = '0;
        busy_nxt    = busy;
        plot_nxt    = vga_plot;
        vga_x_nxt   = vga_x;
        vga_y_nxt   = vga_y;
        colour_nxt  = vga_colour;
        case (state)
            IDLE: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                plot_nxt = 1'b0;
                if (win_valid) begin
                    cur_idx_nxt = win_idx;
                    lat_x_nxt   = sel_x;
                    lat_y_nxt   = sel_y;
                    lat_wm1_nxt = sel_wm1;
                    lat_hm1_nxt = sel_hm1;
                    ox_nxt      = 4'd0;
                    oy_nxt      = 4'd0;
                    gnt_nxt     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    busy_nxt    = 1'b1;
                    plot_nxt    = first_pix[15];
                    vga_x_nxt   = first_pix[14:7];
                    vga_y_nxt   = first_pix[6:0];
                    colour_nxt  = sel_colour;
                end
            end
            DRAW: begin
                if (last_pix) begin
                    gnt_nxt  = '0;
                    done_nxt = gnt;
                    busy_nxt = 1'b0;
                    plot_nxt = 1'b0;
                    ptr_nxt  = (int'(cur_idx) == NUM_REQ-1) ? '0 : cur_idx + PW'(1);
                end else begin
                    ox_nxt    = adv_ox;
                    oy_nxt    = adv_oy;
                    plot_nxt  = adv_pix[15];
                    vga_x_nxt = adv_pix[14:7];
                    vga_y_nxt = adv_pix[6:0];
                end
            end
            default: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                plot_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr        <= '0;
            cur_idx    <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_wm1    <= '0;
            lat_hm1    <= '0;
            ox         <= '0;
            oy         <= '0;
            gnt        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            ptr        <= ptr_nxt;
            cur_idx    <= cur_idx_nxt;
            lat_x      <= lat_x_nxt;
            lat_y      <= lat_y_nxt;
            lat_wm1    <= lat_wm1_nxt;
            lat_hm1    <= lat_hm1_nxt;
            ox         <= ox_nxt;
            oy         <= oy_nxt;
            gnt        <= gnt_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
            vga_plot   <= plot_nxt;
            vga_x      <= vga_x_nxt;
            vga_y      <= vga_y_nxt;
            vga_colour <= colour_nxt;
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: per-cycle vector table plus hand-written
// sequences for arbitration order, late parameter changes and reset mid-draw.
module tb_vga_draw_arbiter;

    localparam int NUM_REQ = 4;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [4*NUM_REQ-1:0] req_wm1;
    logic [4*NUM_REQ-1:0] req_hm1;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           vga_colour;
    logic                 vga_plot;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] x;
        logic [6:0] y;
        logic [3:0] wm1;
        logic [3:0] hm1;
        logic [2:0] col;
        logic [3:0] e_gnt;
        logic [3:0] e_done;
        logic       e_busy;
        logic       e_plot;
        logic       chk_xy;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_col;
    } vec_t;

    vec_t vecs[$];

    vga_draw_arbiter #(.NUM_REQ(NUM_REQ), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clock(clock), .resetn(resetn), .req(req),
        .req_x(req_x), .req_y(req_y), .req_wm1(req_wm1), .req_hm1(req_hm1),
        .req_colour(req_colour), .gnt(gnt), .done(done), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input int r, input int x, input int y, input int wm1,
                                input int hm1, input int col, input int eg, input int ed,
                                input int eb, input int ep, input int cxy, input int ex,
                                input int ey, input int ec);
        vec_t v;
        v.req = 4'(r);     v.x = 8'(x);       v.y = 7'(y);
        v.wm1 = 4'(wm1);   v.hm1 = 4'(hm1);   v.col = 3'(col);
        v.e_gnt = 4'(eg);  v.e_done = 4'(ed); v.e_busy = 1'(eb);
        v.e_plot = 1'(ep); v.chk_xy = 1'(cxy);
        v.e_x = 8'(ex);    v.e_y = 7'(ey);    v.e_col = 3'(ec);
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [3:0] e_gnt,
                              input logic [3:0] e_done, input logic e_busy, input logic e_plot);
        check_output({tag, " gnt"},  32'(gnt),      32'(e_gnt));
        check_output({tag, " done"}, 32'(done),     32'(e_done));
        check_output({tag, " busy"}, 32'(busy),     32'(e_busy));
        check_output({tag, " plot"}, 32'(vga_plot), 32'(e_plot));
    endtask

    task automatic set_slot(input int i, input logic [7:0] x, input logic [6:0] y,
                            input logic [3:0] wm1, input logic [3:0] hm1, input logic [2:0] col);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_wm1[4*i +: 4]    = wm1;
        req_hm1[4*i +: 4]    = hm1;
        req_colour[3*i +: 3] = col;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        req = v.req;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_slot(i, v.x, v.y, v.wm1, v.hm1, v.col);
        end
        tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = '0;
        #3;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        req        = '0;
        req_x      = '0;
        req_y      = '0;
        req_wm1    = '0;
        req_hm1    = '0;
        req_colour = '0;
        resetn     = 1'b0;
        #3;
        check_ctrl("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        check_output("reset vga_x", 32'(vga_x), 32'd0);
        check_output("reset vga_y", 32'(vga_y), 32'd0);
        check_output("reset colour", 32'(vga_colour), 32'd0);
        tick();
        resetn = 1'b1;

        // 2x2 job from requester 1 at (10,20), then its done pulse.
        vecs.push_back(mk(4'b0010, 10, 20, 1, 1, 7, 4'b0010, 0, 1, 1, 1, 10, 20, 7));
        vecs.push_back(mk(4'b0000, 10, 20, 1, 1, 7, 4'b0010, 0, 1, 1, 1, 11, 20, 7));
        vecs.push_back(mk(4'b0000, 10, 20, 1, 1, 7, 4'b0010, 0, 1, 1, 1, 10, 21, 7));
        vecs.push_back(mk(4'b0000, 10, 20, 1, 1, 7, 4'b0010, 0, 1, 1, 1, 11, 21, 7));
        vecs.push_back(mk(4'b0000, 10, 20, 1, 1, 7, 0, 4'b0010, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 10, 20, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        // 4x2 job at the bottom-right corner: only two pixels land on screen.
        vecs.push_back(mk(4'b0100, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 1, 1, 158, 119, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 1, 1, 159, 119, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 0, 1, 160, 119, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 0, 1, 161, 119, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 0, 1, 158, 120, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 0, 1, 159, 120, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 0, 1, 160, 120, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 4'b0100, 0, 1, 0, 1, 161, 120, 5));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 0, 4'b0100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 158, 119, 3, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int r = 0; r < vecs.size(); r++) begin
            apply_stimulus(vecs[r]);
            check_ctrl($sformatf("row%0d", r), vecs[r].e_gnt, vecs[r].e_done,
                       vecs[r].e_busy, vecs[r].e_plot);
            if (vecs[r].chk_xy) begin
                check_output($sformatf("row%0d vga_x", r), 32'(vga_x), 32'(vecs[r].e_x));
                check_output($sformatf("row%0d vga_y", r), 32'(vga_y), 32'(vecs[r].e_y));
                check_output($sformatf("row%0d colour", r), 32'(vga_colour), 32'(vecs[r].e_col));
            end
        end

        // Simultaneous 1x1 requests 0 and 2 from pointer 0; pointer then sits at 3.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_slot(i, 8'd0, 7'd0, 4'd0, 4'd0, 3'd1);
        req = 4'b0101;
        tick(); check_ctrl("sim g0", 4'b0001, 4'b0000, 1'b1, 1'b1);
        req = 4'b0100;
        tick(); check_ctrl("sim d0", 4'b0000, 4'b0001, 1'b0, 1'b0);
        tick(); check_ctrl("sim g2", 4'b0100, 4'b0000, 1'b1, 1'b1);
        req = 4'b0000;
        tick(); check_ctrl("sim d2", 4'b0000, 4'b0100, 1'b0, 1'b0);
        req = 4'b1001;
        tick(); check_ctrl("sim ptr3", 4'b1000, 4'b0000, 1'b1, 1'b1);
        req = 4'b0001;
        tick(); check_ctrl("sim d3", 4'b0000, 4'b1000, 1'b0, 1'b0);
        tick(); check_ctrl("sim wrap0", 4'b0001, 4'b0000, 1'b1, 1'b1);
        req = 4'b0000;
        tick(); check_ctrl("sim dwrap", 4'b0000, 4'b0001, 1'b0, 1'b0);

        // All four requesters held high: strict rotation 0,1,2,3,0,1.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_ctrl($sformatf("rr%0d grant", k), 4'(1 << (k % 4)), 4'b0000, 1'b1, 1'b1);
            tick();
            check_ctrl($sformatf("rr%0d done", k), 4'b0000, 4'(1 << (k % 4)), 1'b0, 1'b0);
        end
        req = 4'b0000;
        tick(); check_ctrl("rr idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // 4x1 job whose x changes right after the grant must keep the latched origin.
        set_slot(0, 8'd40, 7'd5, 4'd3, 4'd0, 3'd2);
        req = 4'b0001;
        tick();
        check_ctrl("late px0", 4'b0001, 4'b0000, 1'b1, 1'b1);
        check_output("late x0", 32'(vga_x), 32'd40);
        set_slot(0, 8'd90, 7'd5, 4'd3, 4'd0, 3'd2);
        req = 4'b0000;
        for (int k = 1; k < 4; k++) begin
            tick();
            check_output($sformatf("late x%0d", k), 32'(vga_x), 32'(40 + k));
            check_output($sformatf("late y%0d", k), 32'(vga_y), 32'd5);
            check_output($sformatf("late col%0d", k), 32'(vga_colour), 32'd2);
        end
        tick(); check_ctrl("late done", 4'b0000, 4'b0001, 1'b0, 1'b0);

        // 16x16 job interrupted by reset while pixel 5 is on the port.
        set_slot(1, 8'd0, 7'd0, 4'd15, 4'd15, 3'd3);
        req = 4'b0010;
        for (int k = 0; k < 6; k++) tick();
        check_ctrl("mid px5", 4'b0010, 4'b0000, 1'b1, 1'b1);
        check_output("mid x5", 32'(vga_x), 32'd5);
        #2;
        resetn = 1'b0;
        #1;
        check_ctrl("mid rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        check_output("mid rst x", 32'(vga_x), 32'd0);
        tick();
        check_ctrl("mid hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
        req    = 4'b0011;
        resetn = 1'b1;
        tick();
        check_ctrl("mid regrant", 4'b0001, 4'b0000, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
